// File: rtl/proc_pkg.sv
// Shared pipeline types: data/register widths, branch encodings, memory-stage FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_t;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_ZERO   = 2'b01,
        BR_POS    = 2'b10,
        BR_ALWAYS = 2'b11
    } br_t;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
// Latency: n/a (wiring only).
// Backpressure: mem_req held until the single-cycle mem_ack.
interface memory_cycle_if;
    import proc_pkg::*;

    data_t mem_addr;
    data_t mem_wdata;
    logic  mem_req;
    logic  mem_we;
    data_t mem_rdata;
    logic  mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/memory_cycle_mem_access_fsm.sv
// Memory-access sequencer: bus registers, stall, optional timeout (MEMORY_CYCLE_TIMEOUT_EN).
// Latency: one IDLE cycle plus one ACCESS cycle per cycle until mem_ack.
// Backpressure: stall high from the request cycle until ack (or timeout abort).
module mem_access_fsm
    import proc_pkg::*;
`ifdef MEMORY_CYCLE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 15
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             memread,
    input  logic             memwrite,
    input  data_t            aluout,
    input  data_t            wdata,
    memory_cycle_if.master   bus,
    output logic             stall,
    output logic             wb_load,
    output logic             access_done,
    output logic             mem_err
);

    mem_state_t state, state_nxt;
    logic       mem_op;
    logic       stall_raw;
    logic       timeout_hit;

    assign mem_op = memread | memwrite;

    always_comb begin
        state_nxt   = state;
        stall_raw   = 1'b0;
        wb_load     = 1'b0;
        access_done = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    state_nxt = MEM_ACCESS;
                end else begin
                    wb_load = 1'b1;
                end
            end
            MEM_ACCESS: begin
                if (bus.mem_ack) begin
                    wb_load     = 1'b1;
                    access_done = 1'b1;
                    state_nxt   = MEM_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = MEM_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    // Reset abandons any access, so upstream must not see a stall while it is held.
    assign stall = stall_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MEM_IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            bus.mem_req <= (state_nxt == MEM_ACCESS);
            if (state == MEM_IDLE && mem_op) begin
                bus.mem_addr  <= aluout;
                bus.mem_wdata <= wdata;
                bus.mem_we    <= memwrite;
            end
        end
    end

`ifdef MEMORY_CYCLE_TIMEOUT_EN
    logic [3:0] to_cnt;
    logic       err_q;

    // Counter holds the number of ack-less ACCESS cycles already completed.
    assign timeout_hit = (state == MEM_ACCESS) && (to_cnt == 4'(TIMEOUT - 1));
    assign mem_err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == MEM_IDLE) begin
                to_cnt <= '0;
            end else if (!bus.mem_ack) begin
                to_cnt <= to_cnt + 4'd1;
            end
            if (timeout_hit && !bus.mem_ack) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: branch resolve, load/store over req/ack bus, MEM/WB register (MEMORY_CYCLE_TIMEOUT_EN).
// Latency: 1 cycle for ALU ops, >=2 cycles for memory ops.
// Backpressure: stall held while a memory access is outstanding.
module memory_cycle
    import proc_pkg::*;
`ifdef MEMORY_CYCLE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 15
)
`endif
(
    input  logic           clk,
    input  logic           rst,
    input  data_t          aluout,
    input  data_t          wdata,
    input  reg_t           rd,
    input  data_t          newpc,
    input  logic           zero,
    input  logic           pos,
    input  logic [1:0]     branch,
    input  logic           memread,
    input  logic           memwrite,
    input  logic           regwrite,
    input  logic           memtoreg,
    memory_cycle_if.master bus,
    output logic           pcsrc,
    output data_t          branch_target,
    output logic           stall,
    output data_t          wb_data,
    output reg_t           wb_rd,
    output logic           wb_regwrite,
    output logic           mem_err
);

    logic wb_load;
    logic access_done;

    always_comb begin
        pcsrc = 1'b0;
        case (branch)
            BR_ZERO:   pcsrc = zero;
            BR_POS:    pcsrc = pos;
            BR_ALWAYS: pcsrc = 1'b1;
            default:   pcsrc = 1'b0;
        endcase
    end

    assign branch_target = newpc;

`ifdef MEMORY_CYCLE_TIMEOUT_EN
    mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
`else
    mem_access_fsm u_fsm (
`endif
        .clk         (clk),
        .rst         (rst),
        .memread     (memread),
        .memwrite    (memwrite),
        .aluout      (aluout),
        .wdata       (wdata),
        .bus         (bus),
        .stall       (stall),
        .wb_load     (wb_load),
        .access_done (access_done),
        .mem_err     (mem_err)
    );

    // Bubbles only clear the write enable; data/rd keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
        end else if (wb_load) begin
            wb_data     <= (access_done && memtoreg) ? bus.mem_rdata : aluout;
            wb_rd       <= rd;
            wb_regwrite <= regwrite;
        end else begin
            wb_regwrite <= 1'b0;
        end
    end

endmodule
